shift_reg_sequencer: RTL and testbench

Controller that shares the 4-bit universal shift register between two requesters. It arbitrates round-robin, parallel-loads the winner's nibble, and issues a fixed number of shift cycles in the requested direction. While shifting it captures the serial output and returns it to the winner with a one-cycle DONE pulse. It sits between the requester logic and the shift register's CLK/ENB/DIR/S_IN/MODO/D/Q/S_OUT interface.

---
 rtl/shift_reg_sequencer_pkg.sv | 25 ++
 rtl/shift_reg_sequencer_if.sv | 28 ++
 rtl/rr_arbiter2.sv | 29 ++
 rtl/shift_reg_sequencer.sv | 126 ++++++++++++
 tb/tb_shift_reg_sequencer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_reg_sequencer_pkg.sv
// Shared shift-register control codes and sequencer state encodings.
// Build option ROTATE_LOOPBACK_EN (consumed by the top) loops S_OUT back to S_IN while shifting.
`ifndef SHIFT_REG_SEQUENCER_DEFINES
`define SHIFT_REG_SEQUENCER_DEFINES
`define ENABLE    1'b1
`define LOW       1'b0
`define HIGH      1'b1
`define SHIFT     2'b00
`define PARA_LOAD 2'b11
`endif

package shift_reg_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_LOAD  = 2'd1,
        SEQ_SHIFT = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/shift_reg_sequencer_if.sv
// Requester and shift-register signals of the sequencer; slave is the sequencer's view,
// master is the view of the requesters plus the shift register.
interface shift_reg_sequencer_if;
    logic [1:0] req;
    logic [1:0] req_dir;
    logic [3:0] req_d0;
    logic [3:0] req_d1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [3:0] rx_data;
    logic       busy;
    logic       enb;
    logic       dir;
    logic       s_in;
    logic [1:0] modo;
    logic [3:0] d;
    logic       s_out;

    modport slave (
        input  req, req_dir, req_d0, req_d1, s_out,
        output gnt, done, rx_data, busy, enb, dir, s_in, modo, d
    );

    modport master (
        output req, req_dir, req_d0, req_d1, s_out,
        input  gnt, done, rx_data, busy, enb, dir, s_in, modo, d
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational winner, pointer moves on the grant pulse.
// Latency: winner same cycle; no backpressure, the caller decides when to grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] gnt,
    output logic       win
);
    // Index of the last granted requester; resets to 1 so requester 0 wins the first tie.
    logic last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= 1'b1;
        end else if (gnt != 2'b00) begin
            last <= gnt[1];
        end
    end

    always_comb begin
        win = 1'b0;
        case (req)
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
    end
endmodule

// File: rtl/shift_reg_sequencer.sv
// Shares a 4-bit universal shift register between two requesters (round-robin, load, shift, capture).
// Latency: GNT 1 cycle after REQ, DONE SHIFT_CYCLES+2 after; requests during BUSY wait. ROTATE_LOOPBACK_EN enables rotation.
module shift_reg_sequencer
    import shift_reg_sequencer_pkg::*;
#(
    parameter int unsigned SHIFT_CYCLES = 4   // legal range 1..4
) (
    input  logic                 clk,
    input  logic                 reset,
    shift_reg_sequencer_if.slave bus
);
    localparam logic [2:0] CNT_INIT = 3'(SHIFT_CYCLES - 1);

    seq_state_t state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       who, who_nxt;
    logic       win;
    logic [1:0] gnt, gnt_nxt;
    logic [1:0] done, done_nxt;
    logic [1:0] modo, modo_nxt;
    logic [3:0] rx, rx_nxt;
    logic [3:0] d, d_nxt;
    logic       busy, busy_nxt;
    logic       enb, enb_nxt;
    logic       dir, dir_nxt;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (reset),
        .req (bus.req),
        .gnt (gnt),
        .win (win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEQ_IDLE;
            cnt   <= '0;
            who   <= 1'b0;
            gnt   <= 2'b00;
            done  <= 2'b00;
            modo  <= `SHIFT;
            rx    <= '0;
            d     <= '0;
            busy  <= 1'b0;
            enb   <= !`ENABLE;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            who   <= who_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            modo  <= modo_nxt;
            rx    <= rx_nxt;
            d     <= d_nxt;
            busy  <= busy_nxt;
            enb   <= enb_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        who_nxt   = who;
        gnt_nxt   = 2'b00;
        done_nxt  = 2'b00;
        modo_nxt  = modo;
        rx_nxt    = rx;
        d_nxt     = d;
        busy_nxt  = busy;
        enb_nxt   = enb;
        dir_nxt   = dir;
        case (state)
            SEQ_IDLE: begin
                if (bus.req != 2'b00) begin
                    state_nxt = SEQ_LOAD;
                    who_nxt   = win;
                    gnt_nxt   = onehot2(win);
                    busy_nxt  = 1'b1;
                    enb_nxt   = `ENABLE;
                    modo_nxt  = `PARA_LOAD;
                    d_nxt     = win ? bus.req_d1 : bus.req_d0;
                    dir_nxt   = bus.req_dir[win];
                    rx_nxt    = '0;
                end
            end
            SEQ_LOAD: begin
                state_nxt = SEQ_SHIFT;
                modo_nxt  = `SHIFT;
                cnt_nxt   = CNT_INIT;
            end
            SEQ_SHIFT: begin
                // S_OUT is the bit leaving on this very edge.
                rx_nxt = {rx[2:0], bus.s_out};
                if (cnt == 3'd0) begin
                    state_nxt = SEQ_DONE;
                    enb_nxt   = !`ENABLE;
                    done_nxt  = onehot2(who);
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            SEQ_DONE: begin
                state_nxt = SEQ_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.gnt     = gnt;
    assign bus.done    = done;
    assign bus.rx_data = rx;
    assign bus.busy    = busy;
    assign bus.enb     = enb;
    assign bus.dir     = dir;
    assign bus.modo    = modo;
    assign bus.d       = d;

`ifdef ROTATE_LOOPBACK_EN
    assign bus.s_in = (state == SEQ_SHIFT) ? bus.s_out : `LOW;
`else
    assign bus.s_in = `LOW;
`endif
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboarded bench: default instance (4 shifts) plus a 2-shift instance, each driving a behavioural shift register.
module tb_shift_reg_sequencer;

    typedef struct {
        logic [1:0] who;
        logic [3:0] rx;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    exp_t gnt_q[$];
    exp_t done_q[$];
    exp_t done2_q[$];
    exp_t ge, de, d2e;

    logic [3:0] q  = 4'b0000;
    logic [3:0] q2 = 4'b0000;

    shift_reg_sequencer_if bus();
    shift_reg_sequencer_if bus2();

    shift_reg_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    shift_reg_sequencer #(.SHIFT_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural universal shift registers; DIR high shifts right (out of Q[0]).
    always @(posedge clk) begin
        if (bus.enb == `ENABLE) begin
            if (bus.modo == `PARA_LOAD)  q <= bus.d;
            else if (bus.dir == `HIGH)   q <= {bus.s_in, q[3:1]};
            else                         q <= {q[2:0], bus.s_in};
        end
        if (bus2.enb == `ENABLE) begin
            if (bus2.modo == `PARA_LOAD) q2 <= bus2.d;
            else if (bus2.dir == `HIGH)  q2 <= {bus2.s_in, q2[3:1]};
            else                         q2 <= {q2[2:0], bus2.s_in};
        end
    end
    assign bus.s_out  = (bus.dir  == `HIGH) ? q[0]  : q[3];
    assign bus2.s_out = (bus2.dir == `HIGH) ? q2[0] : q2[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitors: every grant/done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (bus.gnt != 2'b00) begin
            if (gnt_q.size() == 0) begin
                checks++;
                $display("FAIL gnt_unexpected: got %b, expected no grant", bus.gnt);
            end else begin
                ge = gnt_q.pop_front();
                check("gnt_who", 32'(bus.gnt), 32'(ge.who));
                check("gnt_cycle", cyc, ge.cyc);
            end
        end
        if (bus.done != 2'b00) begin
            if (done_q.size() == 0) begin
                checks++;
                $display("FAIL done_unexpected: got %b, expected no done", bus.done);
            end else begin
                de = done_q.pop_front();
                check("done_who", 32'(bus.done), 32'(de.who));
                check("done_rx", 32'(bus.rx_data), 32'(de.rx));
                check("done_cycle", cyc, de.cyc);
            end
        end
        if (bus2.done != 2'b00) begin
            if (done2_q.size() == 0) begin
                checks++;
                $display("FAIL done2_unexpected: got %b, expected no done", bus2.done);
            end else begin
                d2e = done2_q.pop_front();
                check("done2_who", 32'(bus2.done), 32'(d2e.who));
                check("done2_rx", 32'(bus2.rx_data), 32'(d2e.rx));
                check("done2_cycle", cyc, d2e.cyc);
            end
        end
    end

    task automatic expect_xfer(input logic [1:0] who, input logic [3:0] rx, input int g);
        gnt_q.push_back('{who: who, rx: 4'b0000, cyc: g});
        done_q.push_back('{who: who, rx: rx, cyc: g + 5});
    endtask

    task automatic wait_gnt(input int lim);
        int i = 0;
        while (bus.gnt == 2'b00 && i < lim) begin
            @(negedge clk);
            i++;
        end
        if (bus.gnt == 2'b00) begin
            checks++;
            $display("FAIL gnt_timeout: no grant within %0d cycles", lim);
        end
    endtask

    task automatic wait_done(input int lim);
        int i = 0;
        while (bus.done == 2'b00 && i < lim) begin
            @(negedge clk);
            i++;
        end
        if (bus.done == 2'b00) begin
            checks++;
            $display("FAIL done_timeout: no done within %0d cycles", lim);
        end
    endtask

    task automatic wait_drain(input int lim);
        int i = 0;
        while ((gnt_q.size() != 0 || done_q.size() != 0 || done2_q.size() != 0 ||
                bus.busy || bus2.busy) && i < lim) begin
            @(negedge clk);
            i++;
        end
        if (gnt_q.size() != 0 || done_q.size() != 0 || done2_q.size() != 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d grants, %0d dones, %0d short dones still expected",
                     gnt_q.size(), done_q.size(), done2_q.size());
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gnt"},  32'(bus.gnt), 32'h0);
        check({tag, "_done"}, 32'(bus.done), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check({tag, "_rx"},   32'(bus.rx_data), 32'h0);
        check({tag, "_enb"},  32'(bus.enb), 32'(!`ENABLE));
        check({tag, "_modo"}, 32'(bus.modo), 32'(`SHIFT));
        check({tag, "_dir"},  32'(bus.dir), 32'h0);
        check({tag, "_d"},    32'(bus.d), 32'h0);
        check({tag, "_s_in"}, 32'(bus.s_in), 32'(`LOW));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1;
        bus.req = 2'b00;  bus.req_dir = 2'b00;  bus.req_d0 = 4'h0;  bus.req_d1 = 4'h0;
        bus2.req = 2'b00; bus2.req_dir = 2'b00; bus2.req_d0 = 4'h0; bus2.req_d1 = 4'h0;

        @(negedge clk);
        check_reset_values("rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("idle");

        // Requester 0, right shift of 1000: bits leave as 0,0,0,1; later data change is ignored.
        bus.req_d0 = 4'b1000; bus.req_dir = 2'b01; bus.req = 2'b01;
        k = cyc + 1;
        expect_xfer(2'b01, 4'b0001, k);
        wait_gnt(10);
        check("load_busy", 32'(bus.busy), 32'h1);
        check("load_enb",  32'(bus.enb), 32'(`ENABLE));
        check("load_modo", 32'(bus.modo), 32'(`PARA_LOAD));
        check("load_d",    32'(bus.d), 32'h8);
        check("load_dir",  32'(bus.dir), 32'(`HIGH));
        bus.req = 2'b00; bus.req_d0 = 4'b1111;
        wait_drain(30);

        // Requester 1, left shift of 1000: first bit out is Q[3].
        @(negedge clk);
        bus.req_d1 = 4'b1000; bus.req_dir = 2'b00; bus.req = 2'b10;
        k = cyc + 1;
        expect_xfer(2'b10, 4'b1000, k);
        wait_gnt(10);
        bus.req = 2'b00;
        wait_drain(30);

        // Both requesting continuously: grants alternate 0,1,0,1 every 7 cycles.
        @(negedge clk);
        bus.req_d0 = 4'b0011; bus.req_d1 = 4'b1010; bus.req_dir = 2'b01; bus.req = 2'b11;
        k = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) expect_xfer(2'b01, 4'b1100, k + 7 * i);
            else            expect_xfer(2'b10, 4'b1010, k + 7 * i);
        end
        for (int i = 0; i < 4; i++) begin
            wait_gnt(20);
            if (i == 3) bus.req = 2'b00;
            @(negedge clk);
        end
        wait_drain(30);

        // Reset in the second shift cycle: transfer abandoned, pointer back to requester 0.
        @(negedge clk);
        bus.req_d0 = 4'b0101; bus.req_dir = 2'b01; bus.req = 2'b01;
        k = cyc + 1;
        gnt_q.push_back('{who: 2'b01, rx: 4'b0000, cyc: k});
        wait_gnt(10);
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        check("shift_enb", 32'(bus.enb), 32'(`ENABLE));
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        bus.req_d1 = 4'b0110; bus.req = 2'b11;
        k = cyc + 1;
        expect_xfer(2'b01, 4'b1010, k);
        wait_gnt(10);
        bus.req = 2'b00;
        wait_drain(30);

        // Right shift of 1100: loopback rotates back to 1100, otherwise zeros fill.
        @(negedge clk);
        bus.req_d0 = 4'b1100; bus.req_dir = 2'b01; bus.req = 2'b01;
        k = cyc + 1;
        expect_xfer(2'b01, 4'b0011, k);
        wait_gnt(10);
        bus.req = 2'b00;
        wait_done(20);
`ifdef ROTATE_LOOPBACK_EN
        check("loop_q", 32'(q), 32'hC);
`else
        check("fill_q", 32'(q), 32'h0);
`endif
        wait_drain(30);

        // Two-shift instance: 1011 right gives 0011, DONE three cycles after the grant.
        @(negedge clk);
        bus2.req_d0 = 4'b1011; bus2.req_dir = 2'b01; bus2.req = 2'b01;
        k = cyc + 1;
        done2_q.push_back('{who: 2'b01, rx: 4'b0011, cyc: k + 3});
        @(negedge clk);
        check("short_gnt", 32'(bus2.gnt), 32'h1);
        bus2.req = 2'b00;
        wait_drain(30);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
